// File: rtl/execute_muldiv_unit_pkg.sv
// Shared types for the execute-stage multiply/divide unit: funct3 op codes,
// FSM states and operand-signedness helpers.
package muldiv_types;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } muldiv_state;

  // rs1 is interpreted as two's complement for these ops.
  function automatic logic is_signed_a(muldiv_op op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  // rs2 is interpreted as two's complement for these ops.
  function automatic logic is_signed_b(muldiv_op op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/execute_muldiv_unit_if.sv
// Request/response bundle between the execute-stage controller (master)
// and the multiply/divide unit (slave).
interface execute_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  import muldiv_types::*;

  logic             start;
  muldiv_op         op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (output start, op, a, b, flush, input busy, done, result);
  modport slave  (input start, op, a, b, flush, output busy, done, result);

endinterface

// File: rtl/execute_muldiv_unit_div.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits. The caller guarantees
// rem_in < divisor, so bit WIDTH of the difference is the borrow.
module restoring_div_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem_in, dividend_bit};
  assign diff    = shifted - {1'b0, divisor};
  assign q_bit   = ~diff[WIDTH];
  assign rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/execute_muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit for the execute stage.
// Shift-add multiply (MUL_STEP bits/cycle) and restoring divide (1 bit/cycle)
// on operand magnitudes, sign fix when the result register is loaded.
// Optional macro MULDIV_FUSE_EN adds a last-product / last-quotient reuse
// record that lets a repeated operand pair finish in one cycle.
module execute_muldiv_unit
  import muldiv_types::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 1
) (
  input logic                  clk,
  input logic                  rst,
  execute_muldiv_unit_if.slave bus
);
  localparam int N_MUL = WIDTH / MUL_STEP;
  localparam int N_DIV = WIDTH;
  localparam int CW    = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  muldiv_state        state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  muldiv_op           op_q, op_d;
  logic               neg_main_q, neg_main_d;  // product or quotient sign
  logic               neg_rem_q, neg_rem_d;    // remainder sign
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   quo_q, quo_d;            // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic               sa_in, sb_in, div_zero, div_ovf;
  logic [WIDTH-1:0]   mag_a_in, mag_b_in;
  logic [WIDTH-1:0]   core_rem;
  logic               core_q;
  logic [2*WIDTH-1:0] fix_prod;
  logic [WIDTH-1:0]   fix_quo, fix_rem;

`ifdef MULDIV_FUSE_EN
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               rec_hit, mul_hit, div_hit;
  logic               mul_rec_vld_q, mul_rec_sa_q, mul_rec_sb_q;
  logic [WIDTH-1:0]   mul_rec_a_q, mul_rec_b_q;
  logic [2*WIDTH-1:0] mul_rec_prod_q;
  logic               div_rec_vld_q, div_rec_sgn_q;
  logic [WIDTH-1:0]   div_rec_a_q, div_rec_b_q, div_rec_quo_q, div_rec_rem_q;

  // MUL/MULH share signedness (1,1); plain MUL only needs the low half,
  // which is identical for every signedness pair.
  assign mul_hit = mul_rec_vld_q && bus.a == mul_rec_a_q && bus.b == mul_rec_b_q &&
                   (bus.op == OP_MUL || (is_signed_a(bus.op) == mul_rec_sa_q &&
                                         is_signed_b(bus.op) == mul_rec_sb_q));
  assign div_hit = div_rec_vld_q && bus.a == div_rec_a_q && bus.b == div_rec_b_q &&
                   is_signed_a(bus.op) == div_rec_sgn_q;
`endif

  // Operand magnitudes and fast-path detection on the incoming request.
  assign sa_in    = is_signed_a(bus.op) & bus.a[WIDTH-1];
  assign sb_in    = is_signed_b(bus.op) & bus.b[WIDTH-1];
  assign mag_a_in = sa_in ? -bus.a : bus.a;
  assign mag_b_in = sb_in ? -bus.b : bus.b;
  assign div_zero = (bus.b == '0);
  assign div_ovf  = is_signed_a(bus.op) && bus.a == MIN_NEG && bus.b == '1;

  restoring_div_core #(.WIDTH(WIDTH)) u_div_step (
    .rem_in       (rem_q),
    .dividend_bit (quo_q[WIDTH-1]),
    .divisor      (dvsr_q),
    .rem_out      (core_rem),
    .q_bit        (core_q)
  );

  // Next-state logic, datapath iteration and fast-path selection.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    neg_main_d = neg_main_q;
    neg_rem_d  = neg_rem_q;
    prod_d     = prod_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dvsr_d     = dvsr_q;
`ifdef MULDIV_FUSE_EN
    a_d        = a_q;
    b_d        = b_q;
    rec_hit    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.flush) begin
          op_d       = bus.op;
          neg_main_d = sa_in ^ sb_in;
          neg_rem_d  = sa_in;
          cnt_d      = '0;
`ifdef MULDIV_FUSE_EN
          a_d        = bus.a;
          b_d        = bus.b;
`endif
          if (!bus.op[2]) begin
            prod_d   = '0;
            mcand_d  = {{WIDTH{1'b0}}, mag_a_in};
            mplier_d = mag_b_in;
            state_d  = ST_MUL;
`ifdef MULDIV_FUSE_EN
            if (mul_hit) begin
              prod_d     = mul_rec_prod_q;
              neg_main_d = 1'b0;
              rec_hit    = 1'b1;
              state_d    = ST_DONE;
            end
`endif
          end else begin
            quo_d   = mag_a_in;
            rem_d   = '0;
            dvsr_d  = mag_b_in;
            state_d = ST_DIV;
            if (div_zero) begin
              quo_d      = '1;
              rem_d      = bus.a;
              neg_main_d = 1'b0;
              neg_rem_d  = 1'b0;
              state_d    = ST_DONE;
            end else if (div_ovf) begin
              quo_d      = bus.a;
              rem_d      = '0;
              neg_main_d = 1'b0;
              neg_rem_d  = 1'b0;
              state_d    = ST_DONE;
            end
`ifdef MULDIV_FUSE_EN
            else if (div_hit) begin
              quo_d      = div_rec_quo_q;
              rem_d      = div_rec_rem_q;
              neg_main_d = 1'b0;
              neg_rem_d  = 1'b0;
              rec_hit    = 1'b1;
              state_d    = ST_DONE;
            end
`endif
          end
        end
      end
      ST_MUL: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          prod_d   = prod_q + mcand_q * (2*WIDTH)'(mplier_q[MUL_STEP-1:0]);
          mcand_d  = mcand_q << MUL_STEP;
          mplier_d = mplier_q >> MUL_STEP;
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == CW'(N_MUL - 1)) begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end
        end
      end
      ST_DIV: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          rem_d = core_rem;
          quo_d = {quo_q[WIDTH-2:0], core_q};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(N_DIV - 1)) begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;  // DONE always returns to IDLE
    endcase
  end

  // Sign fix and result selection on the values that enter DONE.
  always_comb begin
    fix_prod = neg_main_d ? -prod_d : prod_d;
    fix_quo  = neg_main_d ? -quo_d  : quo_d;
    fix_rem  = neg_rem_d  ? -rem_d  : rem_d;
    case (op_d)
      OP_MUL:                        result_d = fix_prod[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  result_d = fix_prod[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:               result_d = fix_quo;
      default:                       result_d = fix_rem;
    endcase
  end

  // State, datapath and result registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= OP_MUL;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      prod_q     <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      dvsr_q     <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      neg_main_q <= neg_main_d;
      neg_rem_q  <= neg_rem_d;
      prod_q     <= prod_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dvsr_q     <= dvsr_d;
      if (state_d == ST_DONE) result_q <= result_d;
    end
  end

`ifdef MULDIV_FUSE_EN
  // Reuse records: written when a computed op enters DONE, kept across flush.
  // A fused hit leaves the record alone so its signedness key stays truthful.
  always_ff @(posedge clk) begin
    // NOTE: the records carry valid bits that must clear on reset; the data
    // fields are reset too so a stale key can never match after reset.
    if (rst) begin
      a_q            <= '0;
      b_q            <= '0;
      mul_rec_vld_q  <= 1'b0;
      mul_rec_sa_q   <= 1'b0;
      mul_rec_sb_q   <= 1'b0;
      mul_rec_a_q    <= '0;
      mul_rec_b_q    <= '0;
      mul_rec_prod_q <= '0;
      div_rec_vld_q  <= 1'b0;
      div_rec_sgn_q  <= 1'b0;
      div_rec_a_q    <= '0;
      div_rec_b_q    <= '0;
      div_rec_quo_q  <= '0;
      div_rec_rem_q  <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      if (state_d == ST_DONE && !rec_hit) begin
        if (!op_d[2]) begin
          mul_rec_vld_q  <= 1'b1;
          mul_rec_sa_q   <= is_signed_a(op_d);
          mul_rec_sb_q   <= is_signed_b(op_d);
          mul_rec_a_q    <= a_d;
          mul_rec_b_q    <= b_d;
          mul_rec_prod_q <= fix_prod;
        end else begin
          div_rec_vld_q  <= 1'b1;
          div_rec_sgn_q  <= is_signed_a(op_d);
          div_rec_a_q    <= a_d;
          div_rec_b_q    <= b_d;
          div_rec_quo_q  <= fix_quo;
          div_rec_rem_q  <= fix_rem;
        end
      end
    end
  end
`endif

  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Self-checking bench for execute_muldiv_unit: directed vectors with fixed
// expected values, randomized ops against an arithmetic reference model,
// flush/reset/handshake scenarios and the optional reuse record.
module tb_execute_muldiv_unit;
  import muldiv_types::*;

  localparam int WIDTH    = 32;
  localparam int MUL_STEP = 1;
  localparam int N_MUL    = WIDTH / MUL_STEP;
  localparam int N_DIV    = WIDTH;
  localparam int MAX_WAIT = 100;
  localparam logic [31:0] MIN_NEG = 32'h8000_0000;
`ifdef MULDIV_FUSE_EN
  localparam bit FUSE = 1'b1;
`else
  localparam bit FUSE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  execute_muldiv_unit_if #(.WIDTH(WIDTH)) bus ();

  execute_muldiv_unit #(.WIDTH(WIDTH), .MUL_STEP(MUL_STEP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference copy of the reuse records (only consulted when FUSE is set).
  bit          mrec_vld, mrec_sa, mrec_sb, drec_vld, drec_sgn;
  logic [31:0] mrec_a, mrec_b, drec_a, drec_b;

  function automatic bit sgn_a(logic [2:0] op);
    return op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6};
  endfunction

  function automatic bit sgn_b(logic [2:0] op);
    return op inside {3'd0, 3'd1, 3'd4, 3'd6};
  endfunction

  // RV32M semantics computed with 64-bit arithmetic.
  function automatic logic [31:0] model_result(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    p  = '0;
    case (op)
      3'd0: begin p = 64'(sa * sb); r = p[31:0]; end
      3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
      3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      3'd4: if (b == 0) r = '1; else if (a == MIN_NEG && b == '1) r = a; else r = 32'(sa / sb);
      3'd5: r = (b == 0) ? '1 : a / b;
      3'd6: if (b == 0) r = a; else if (a == MIN_NEG && b == '1) r = '0; else r = 32'(sa % sb);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Expected start-to-done latency in cycles and whether a record was reused.
  task automatic calc_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output bit hit);
    hit = 1'b0;
    if (op[2]) begin
      if (b == 0 || (sgn_a(op) && a == MIN_NEG && b == '1)) lat = 1;
      else if (FUSE && drec_vld && a == drec_a && b == drec_b && sgn_a(op) == drec_sgn) begin
        lat = 1; hit = 1'b1;
      end else lat = N_DIV + 1;
    end else begin
      if (FUSE && mrec_vld && a == mrec_a && b == mrec_b &&
          (op == 3'd0 || (sgn_a(op) == mrec_sa && sgn_b(op) == mrec_sb))) begin
        lat = 1; hit = 1'b1;
      end else lat = N_MUL + 1;
    end
  endtask

  task automatic clear_records();
    mrec_vld = 1'b0;
    drec_vld = 1'b0;
  endtask

  // Issue one op at the current cycle (cycle 0) and follow it to completion.
  // With hold set, start stays high through busy and the DONE cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input bit hold, input string tag);
    int lat;
    bit hit;
    bit seen;
    calc_lat(op, a, b, lat, hit);
    bus.start = 1'b1;
    bus.op    = muldiv_op'(op);
    bus.a     = a;
    bus.b     = b;
    seen      = 1'b0;
    for (int cyc = 1; cyc <= MAX_WAIT && !seen; cyc++) begin
      @(posedge clk); #1;
      if (!hold) bus.start = 1'b0;
      tests_run++;
      if (bus.busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL %s busy: cycle %0d busy=%b required 1", tag, cyc, bus.busy);
      end
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        tests_run++;
        if (cyc != lat) begin
          tests_failed++;
          $display("FAIL %s latency: done in cycle %0d required %0d", tag, cyc, lat);
        end
        tests_run++;
        if (bus.result !== exp_res) begin
          tests_failed++;
          $display("FAIL %s result: got %h required %h", tag, bus.result, exp_res);
        end
      end
    end
    if (!seen) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s timeout: no done within %0d cycles", tag, MAX_WAIT);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s idle after done: busy=%b done=%b required 0/0", tag, bus.busy, bus.done);
    end
    tests_run++;
    if (bus.result !== exp_res) begin
      tests_failed++;
      $display("FAIL %s result hold: got %h required %h", tag, bus.result, exp_res);
    end
    if (!hit) begin
      if (!op[2]) begin
        mrec_vld = 1'b1; mrec_a = a; mrec_b = b; mrec_sa = sgn_a(op); mrec_sb = sgn_b(op);
      end else begin
        drec_vld = 1'b1; drec_a = a; drec_b = b; drec_sgn = sgn_a(op);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_records();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset state: busy=%b done=%b result=%h required 0/0/0",
               bus.busy, bus.done, bus.result);
    end
    rst = 1'b0;
    clear_records();
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;

  task automatic test_directed();
    vec_t v [17];
    v[0]  = '{3'd0, 32'd7,         32'd6,         32'h0000_002A};
    v[1]  = '{3'd1, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF};
    v[2]  = '{3'd3, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001};
    v[3]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF};
    v[4]  = '{3'd2, 32'd2,         32'hFFFF_FFFF, 32'h0000_0001};
    v[5]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
    v[6]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
    v[7]  = '{3'd5, 32'd100,       32'd7,         32'd14};
    v[8]  = '{3'd7, 32'd100,       32'd7,         32'd2};
    v[9]  = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF};
    v[10] = '{3'd7, 32'd5,         32'd0,         32'd5};
    v[11] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    v[12] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
    v[13] = '{3'd4, 32'd7,         32'd0,         32'hFFFF_FFFF};
    v[14] = '{3'd0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1};
    v[15] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    v[16] = '{3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1};
    foreach (v[i]) run_op(v[i].op, v[i].a, v[i].b, v[i].res, bit'(i % 2), $sformatf("directed%0d", i));
  endtask

  task automatic test_flush();
    int flush_cyc;
    flush_cyc = (N_MUL < 10) ? N_MUL : 10;
    run_op(3'd5, 32'd100, 32'd7, 32'd14, 1'b0, "flush_pre");
    bus.start = 1'b1;
    bus.op    = OP_MUL;
    bus.a     = 32'h0000_1357;
    bus.b     = 32'h0000_2468;
    for (int cyc = 1; cyc <= flush_cyc; cyc++) begin
      @(posedge clk); #1;
      tests_run++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        tests_failed++;
        $display("FAIL flush in flight: cycle %0d busy=%b done=%b required 1/0", cyc, bus.busy, bus.done);
      end
      bus.start = (cyc >= 2 && cyc < flush_cyc);
      bus.op    = OP_DIVU;
      bus.a     = 32'd9;
      bus.b     = 32'd0;
      bus.flush = (cyc == flush_cyc);
    end
    @(posedge clk); #1;
    bus.flush = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'd14) begin
      tests_failed++;
      $display("FAIL flush kill: busy=%b done=%b result=%h required 0/0/0000000e",
               bus.busy, bus.done, bus.result);
    end
    // flush beats start while idle
    bus.start = 1'b1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.result !== 32'd14) begin
      tests_failed++;
      $display("FAIL flush over start: busy=%b result=%h required 0/0000000e", bus.busy, bus.result);
    end
    run_op(3'd0, 32'd3, 32'd3, 32'd9, 1'b0, "flush_post");
  endtask

  task automatic test_reset_mid_op();
    bus.start = 1'b1;
    bus.op    = OP_DIV;
    bus.a     = 32'h0000_DEAD;
    bus.b     = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst       = 1'b1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    rst       = 1'b0;
    bus.flush = 1'b0;
    clear_records();
    tests_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset mid op: busy=%b done=%b result=%h required 0/0/0",
               bus.busy, bus.done, bus.result);
    end
  endtask

  task automatic test_fuse();
    logic [31:0] x, y;
    x = 32'h1234_5678;
    y = 32'h9ABC_DEF0;
    run_op(3'd3, x, y, model_result(3'd3, x, y), 1'b0, "fuse_mulhu");
    run_op(3'd0, x, y, model_result(3'd0, x, y), 1'b0, "fuse_mul");
    run_op(3'd1, x, y, model_result(3'd1, x, y), 1'b1, "fuse_mulh");
    run_op(3'd4, 32'hFFFF_FC18, 32'd7, model_result(3'd4, 32'hFFFF_FC18, 32'd7), 1'b0, "fuse_div");
    run_op(3'd6, 32'hFFFF_FC18, 32'd7, model_result(3'd6, 32'hFFFF_FC18, 32'd7), 1'b0, "fuse_rem");
    run_op(3'd7, 32'hFFFF_FC18, 32'd7, model_result(3'd7, 32'hFFFF_FC18, 32'd7), 1'b0, "fuse_remu");
    do_reset();
    run_op(3'd0, x, y, model_result(3'd0, x, y), 1'b0, "fuse_after_reset");
  endtask

  task automatic test_back_to_back();
    run_op(3'd5, 32'd11, 32'd0, 32'hFFFF_FFFF, 1'b1, "b2b0");
    run_op(3'd7, 32'd11, 32'd0, 32'd11,        1'b0, "b2b1");
    run_op(3'd4, MIN_NEG, 32'hFFFF_FFFF, MIN_NEG, 1'b1, "b2b2");
    run_op(3'd0, 32'd12, 32'd12, 32'd144,      1'b0, "b2b3");
    run_op(3'd6, 32'd13, 32'd0, 32'd13,        1'b1, "b2b4");
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return MIN_NEG;
      4:       return 32'($urandom_range(0, 255));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = rand_operand();
      b  = rand_operand();
      if ($urandom_range(0, 5) == 0) b = a;
      run_op(op, a, b, model_result(op, a, b), bit'($urandom_range(0, 1)), $sformatf("random%0d", i));
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = OP_MUL;
    bus.a     = '0;
    bus.b     = '0;
    rst       = 1'b1;
    clear_records();
    test_reset();
    test_flush();
    test_directed();
    test_reset_mid_op();
    test_fuse();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
